// File: rtl/uart_retrans_pkg.sv
// uart_retrans_pkg: shared types, defaults and helpers for the UART retransmission FSMs
package uart_retrans_pkg;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES = 2;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_DONE, S_FAIL} state_e;
  // Counter width for n distinct values, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_timeout_ctr.sv
// uart_timeout_ctr: saturating cycle counter flagging when LIMIT-1 is reached
// Ports: clk, reset_n (async active-low), clr (zero the count), en (count up), expired (count == LIMIT-1)
module uart_timeout_ctr
  import uart_retrans_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = cnt_w(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Holding at LAST keeps the count from wrapping while en stays high.
  always_comb cnt_d = clr ? '0 : (en && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == LAST;
endmodule

// File: rtl/uart_retrans_tx_fsm.sv
// uart_retrans_tx_fsm: transmit-side retransmission controller with bounded retries
// Ports: clk, reset_n (async active-low); host: send, data_in, busy, done, fail, retry_count;
//        serializer: tx_busy, tx_done, tx_start, tx_data, tx_parity; receiver: ack_in, resend_req, rx_error
module uart_retrans_tx_fsm
  import uart_retrans_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  send,
  input  logic [DATA_W-1:0]                     data_in,
  input  logic                                  tx_busy,
  input  logic                                  tx_done,
  input  logic                                  ack_in,
  input  logic                                  resend_req,
  input  logic                                  rx_error,
  output logic                                  tx_start,
  output logic [DATA_W-1:0]                     tx_data,
  output logic                                  tx_parity,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  fail,
  output logic [cnt_w(MAX_RETRIES+1)-1:0]       retry_count
);
  localparam int RW = cnt_w(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
  state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0] retry_q, retry_d;
  logic timeout;
  // Counter runs only in WAIT_ACK and is forced to zero everywhere else.
  uart_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != S_WAIT_ACK),
    .en      (state_q == S_WAIT_ACK),
    .expired (timeout)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: if (send) begin
        data_d = data_in;
        retry_d = '0;
        state_d = S_SEND;
      end
      S_SEND: state_d = tx_busy ? S_SEND : S_WAIT_TX;
      S_WAIT_TX: state_d = tx_done ? S_WAIT_ACK : S_WAIT_TX;
      S_WAIT_ACK:
        if (ack_in) state_d = S_DONE;
        else if (rx_error) state_d = S_FAIL;
        else if (resend_req || timeout) begin
          state_d = (retry_q < RMAX) ? S_SEND : S_FAIL;
          retry_d = (retry_q < RMAX) ? retry_q + 1'b1 : retry_q;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      retry_q <= retry_d;
    end
  assign tx_start = state_q == S_SEND && !tx_busy;
  assign tx_data = data_q;
  assign tx_parity = even_parity(64'(data_q));
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign fail = state_q == S_FAIL;
  assign retry_count = retry_q;
endmodule

// File: tb/tb_uart_retrans_tx_fsm.sv
// tb_uart_retrans_tx_fsm: directed self-checking bench for uart_retrans_tx_fsm
module tb_uart_retrans_tx_fsm;
  logic clk, reset_n, send, tx_busy, tx_done, ack_in, resend_req, rx_error;
  logic [7:0] data_in, tx_data;
  logic tx_start, tx_parity, busy, done, fail;
  logic [1:0] retry_count;
  int checks = 0, errors = 0;
  int n_start = 0, n_done = 0, n_fail = 0;
  int s0, d0, f0;

  uart_retrans_tx_fsm #(.DATA_W(8), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
    .clk(clk), .reset_n(reset_n), .send(send), .data_in(data_in), .tx_busy(tx_busy),
    .tx_done(tx_done), .ack_in(ack_in), .resend_req(resend_req), .rx_error(rx_error),
    .tx_start(tx_start), .tx_data(tx_data), .tx_parity(tx_parity), .busy(busy),
    .done(done), .fail(fail), .retry_count(retry_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (done) n_done++;
    if (fail) n_fail++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] d);
    send = 1; data_in = d;
    tick(1);
    send = 0;
  endtask

  task automatic pulse_txdone();
    tx_done = 1;
    tick(1);
    tx_done = 0;
  endtask

  task automatic snap();
    s0 = n_start; d0 = n_done; f0 = n_fail;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    checks++; if ({tx_start, tx_parity, done, fail} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000", {tx_start, tx_parity, done, fail}); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    reset_n = 1;
    tick(1);
  endtask

  task automatic test_clean_frame();
    snap();
    launch(8'hA5);
    checks++; if (tx_start !== 1) begin errors++; $display("FAIL clean_start: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL clean_data: got %h want a5", tx_data); end
    checks++; if (tx_parity !== 0) begin errors++; $display("FAIL clean_parity: got %b want 0", tx_parity); end
    checks++; if (busy !== 1) begin errors++; $display("FAIL clean_busy: got %b want 1", busy); end
    tick(9);
    pulse_txdone();
    tick(2);
    ack_in = 1; tick(1); ack_in = 0;
    checks++; if (done !== 1) begin errors++; $display("FAIL clean_done: got %b want 1", done); end
    tick(1);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL clean_idle: got %b want 00", {done, busy}); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL clean_retry: got %0d want 0", retry_count); end
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL clean_nstart: got %0d want 1", n_start - s0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL clean_ndone: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_parity_resend();
    snap();
    launch(8'h07);
    tick(1);
    pulse_txdone();
    resend_req = 1; tick(1); resend_req = 0;
    checks++; if (tx_start !== 1) begin errors++; $display("FAIL resend_start: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'h07) begin errors++; $display("FAIL resend_data: got %h want 07", tx_data); end
    checks++; if (tx_parity !== 1) begin errors++; $display("FAIL resend_parity: got %b want 1", tx_parity); end
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL resend_retry: got %0d want 1", retry_count); end
    tick(1);
    pulse_txdone();
    ack_in = 1; tick(1); ack_in = 0;
    checks++; if (done !== 1) begin errors++; $display("FAIL resend_done: got %b want 1", done); end
    tick(1);
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL resend_retry_idle: got %0d want 1", retry_count); end
    checks++; if (n_start - s0 !== 2) begin errors++; $display("FAIL resend_nstart: got %0d want 2", n_start - s0); end
  endtask

  task automatic test_exhaustion();
    snap();
    launch(8'h3C);
    tick(1);
    for (int r = 1; r <= 2; r++) begin
      pulse_txdone();
      tick(15);
      checks++; if ({tx_start, busy} !== 2'b01) begin errors++; $display("FAIL exh_early%0d: got %b want 01", r, {tx_start, busy}); end
      tick(1);
      checks++; if (tx_start !== 1) begin errors++; $display("FAIL exh_start%0d: got %b want 1", r, tx_start); end
      checks++; if (retry_count !== 2'(r)) begin errors++; $display("FAIL exh_retry%0d: got %0d want %0d", r, retry_count, r); end
      checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL exh_data%0d: got %h want 3c", r, tx_data); end
      tick(1);
    end
    pulse_txdone();
    tick(15);
    checks++; if (fail !== 0) begin errors++; $display("FAIL exh_fail_early: got %b want 0", fail); end
    tick(1);
    checks++; if (fail !== 1) begin errors++; $display("FAIL exh_fail: got %b want 1", fail); end
    checks++; if (retry_count !== 2'd2) begin errors++; $display("FAIL exh_retry_final: got %0d want 2", retry_count); end
    tick(1);
    checks++; if ({fail, busy} !== 2'b00) begin errors++; $display("FAIL exh_idle: got %b want 00", {fail, busy}); end
    checks++; if (n_start - s0 !== 3) begin errors++; $display("FAIL exh_nstart: got %0d want 3", n_start - s0); end
    checks++; if (n_fail - f0 !== 1) begin errors++; $display("FAIL exh_nfail: got %0d want 1", n_fail - f0); end
  endtask

  task automatic test_priorities();
    snap();
    launch(8'h11);
    tick(1);
    pulse_txdone();
    ack_in = 1; resend_req = 1; tick(1); ack_in = 0; resend_req = 0;
    checks++; if ({done, fail, tx_start} !== 3'b100) begin errors++; $display("FAIL prio_ack: got %b want 100", {done, fail, tx_start}); end
    tick(1);
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL prio_ack_nstart: got %0d want 1", n_start - s0); end
    launch(8'h22);
    tick(1);
    pulse_txdone();
    rx_error = 1; tick(1); rx_error = 0;
    checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL prio_err: got %b want 01", {done, fail}); end
    tick(1);
    launch(8'h33);
    tick(1);
    pulse_txdone();
    rx_error = 1; resend_req = 1; tick(1); rx_error = 0; resend_req = 0;
    checks++; if ({fail, tx_start} !== 2'b10) begin errors++; $display("FAIL prio_err_resend: got %b want 10", {fail, tx_start}); end
    tick(1);
  endtask

  task automatic test_busy_ignore();
    snap();
    tx_busy = 1;
    launch(8'h5A);
    checks++; if ({tx_start, busy} !== 2'b01) begin errors++; $display("FAIL busy_hold0: got %b want 01", {tx_start, busy}); end
    for (int i = 1; i < 5; i++) begin
      tick(1);
      checks++; if (tx_start !== 0) begin errors++; $display("FAIL busy_hold%0d: got %b want 0", i, tx_start); end
    end
    tx_busy = 0;
    #1;
    checks++; if (tx_start !== 1) begin errors++; $display("FAIL busy_release: got %b want 1", tx_start); end
    tick(1);
    pulse_txdone();
    send = 1; data_in = 8'hFF; tick(1); send = 0;
    checks++; if ({tx_data, busy} !== {8'h5A, 1'b1}) begin errors++; $display("FAIL ignore_send: got %h/%b want 5a/1", tx_data, busy); end
    ack_in = 1; tick(1); ack_in = 0;
    tick(1);
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL ignore_data_idle: got %h want 5a", tx_data); end
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL busy_nstart: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_reset_mid_frame();
    snap();
    launch(8'h81);
    tick(1);
    pulse_txdone();
    reset_n = 0;
    #1;
    checks++; if ({busy, tx_start, done, fail, tx_parity} !== 5'b0) begin errors++; $display("FAIL rst_mid_outs: got %b want 00000", {busy, tx_start, done, fail, tx_parity}); end
    checks++; if ({tx_data, retry_count} !== 10'b0) begin errors++; $display("FAIL rst_mid_regs: got %h/%0d want 00/0", tx_data, retry_count); end
    tick(2);
    reset_n = 1;
    tick(1);
    checks++; if (n_fail - f0 !== 0) begin errors++; $display("FAIL rst_mid_nfail: got %0d want 0", n_fail - f0); end
    test_clean_frame();
  endtask

  initial begin
    reset_n = 0; send = 0; data_in = 0; tx_busy = 0; tx_done = 0;
    ack_in = 0; resend_req = 0; rx_error = 0;
    test_reset();
    test_clean_frame();
    test_parity_resend();
    test_exhaustion();
    test_priorities();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_retrans_tx_fsm.md
# uart_retrans_tx_fsm

Transmit-side retransmission controller for the UART link. It accepts a data word from the host, hands it with an even-parity bit to the byte serializer, and waits for the far-end receiver's verdict. On a resend request or an ack timeout it retransmits the held frame, up to a bounded retry count. It reports done or fail to the host. It sits between the host interface and the UART serializer, and consumes the receiver's `ack`/`request_resend`/`error` lines.

## Interface
- `DATA_W`, 8, frame payload width
- `TIMEOUT_CYCLES`, 1000, clk cycles in WAIT_ACK before a timeout (≥2)
- `MAX_RETRIES`, 2, retransmissions allowed after the first send (≥0)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `send`  in  1  host start strobe; sampled only in IDLE
- `data_in`  in  DATA_W  payload, captured when `send` is accepted
- `tx_busy`  in  1  serializer busy
- `tx_done`  in  1  serializer one-cycle pulse: frame fully shifted out
- `ack_in`  in  1  receiver accepted the frame
- `resend_req`  in  1  receiver requests retransmission (parity error)
- `rx_error`  in  1  receiver gave up
- `tx_start`  out  1  one-cycle launch strobe to the serializer
- `tx_data`  out  DATA_W  held frame payload
- `tx_parity`  out  1  even parity of `tx_data` (XOR-reduce)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle success pulse
- `fail`  out  1  one-cycle failure pulse
- `retry_count`  out  clog2(MAX_RETRIES+1)  retransmissions used for the current frame

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_ACK, DONE, FAIL.
- IDLE:
  - `send`=1 → capture `data_in` into `tx_data`, clear `retry_count`, go to SEND.
  - `send` is ignored in all other states.
- SEND:
  - `tx_start` = (state==SEND) && !`tx_busy`.
  - In the cycle `tx_start` is high, go to WAIT_TX.
  - While `tx_busy`=1, stay in SEND.
- WAIT_TX: on `tx_done`, go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - The counter increments each cycle. Timeout = counter == TIMEOUT_CYCLES-1.
  - Events are evaluated in fixed priority order:
    1. `ack_in` → DONE.
    2. `rx_error` → FAIL.
    3. `resend_req` or timeout, with `retry_count` < MAX_RETRIES → increment `retry_count`, go to SEND.
    4. `resend_req` or timeout, with `retry_count` == MAX_RETRIES → FAIL.
  - `ack_in`/`resend_req`/`rx_error` are ignored outside WAIT_ACK.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- FAIL: `fail`=1 for exactly one cycle, then IDLE.
- `tx_data`/`tx_parity` are stable from capture until the next accepted `send`, including across all retries.
- `retry_count` keeps its value in IDLE until the next accepted `send`.
- Counter width is clog2(TIMEOUT_CYCLES). The counter saturates and does not wrap. It is held at 0 outside WAIT_ACK.
- Reset (any time, including mid-frame):
  - Immediate return to IDLE.
  - All outputs go to 0: `tx_data`=0, `tx_parity`=0, `retry_count`=0, `busy`=0, `done`=0, `fail`=0, `tx_start`=0.
  - Counter = 0.
  - An in-flight frame is abandoned with no `fail` pulse.

## Timing
- `send` accepted at edge N → SEND from N+1. With `tx_busy`=0, `tx_start` is high during cycle N+1.
- `tx_done` at edge M → WAIT_ACK from M+1.
- With no response, timeout fires in the TIMEOUT_CYCLES-th cycle spent in WAIT_ACK.
- `ack_in` sampled at edge K → `done` high in cycle K+1 → IDLE at K+2. A new `send` is accepted from K+2.
- All outputs except `tx_start` are pure register/state decodes. `tx_start` is combinational on state and `tx_busy` only.
- Simultaneous `ack_in` and timeout in the same cycle → DONE.
- Simultaneous `resend_req` and `rx_error` in the same cycle → FAIL.

## Structure
- Package `uart_retrans_pkg`: state enum, `TIMEOUT_CYCLES`/`MAX_RETRIES` defaults, parity function. Shared with the receive-side FSM.
- One sub-module: `uart_timeout_ctr` (saturating counter with `clr`, `en`, `expired`). It is reused by the receive side.

## Test plan
All scenarios use TIMEOUT_CYCLES=16 and MAX_RETRIES=2.
- Clean frame: `send` with `data_in`=0xA5, `tx_done` after 10 cycles, `ack_in` 3 cycles later → one `tx_start`, `tx_parity`=0, `done` pulse, `retry_count`=0.
- Parity resend: `data_in`=0x07, `resend_req` once, then `ack_in` → two `tx_start` pulses with the same data, `tx_parity`=1, `done`, `retry_count`=1.
- Exhaustion: no response ever → 3 `tx_start` pulses, each 16 cycles after the preceding `tx_done`, then `fail`, `retry_count`=2.
- Priorities:
  - `ack_in` and `resend_req` in the same cycle → `done`, no retransmit.
  - `rx_error` in WAIT_ACK → `fail` next cycle.
- Busy/ignore: `tx_busy` held high 5 cycles in SEND → `tx_start` is delayed until `tx_busy` falls. `send` pulsed in WAIT_ACK → ignored, `tx_data` unchanged.
- Reset mid-frame: `reset_n` low in WAIT_ACK → same-cycle IDLE, all outputs 0, no `fail`. The next `send` behaves like the clean-frame case.
